spi_dma: RTL

SPI_DMA -- requirements
Module: spi_dma

---
 rtl/spi_dma_pkg.sv | 43 ++++
 rtl/spi_dma.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_dma_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spi_dma_pkg
//  Purpose  : Shared definitions for the SPI <-> data-memory DMA engine:
//             FSM state encoding, CPU register indices, CTRL bit positions
//             and the fill byte sent when transmit-from-memory is disabled.
//  Revision : 1.0  initial release
// ============================================================================
package spi_dma_pkg;

    // Transfer sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RD        = 3'd1,
        ST_RD_WAIT   = 3'd2,
        ST_XFER      = 3'd3,
        ST_XFER_WAIT = 3'd4,
        ST_WR        = 3'd5,
        ST_FIN       = 3'd6
    } state_t;

    // CPU-visible register indices (cfg_addr).
    localparam logic [2:0] c_reg_src    = 3'd0;
    localparam logic [2:0] c_reg_dst    = 3'd1;
    localparam logic [2:0] c_reg_len    = 3'd2;
    localparam logic [2:0] c_reg_ctrl   = 3'd3;
    localparam logic [2:0] c_reg_status = 3'd4;

    // CTRL bit positions.
    localparam int c_ctrl_start = 0;
    localparam int c_ctrl_tx_en = 1;
    localparam int c_ctrl_rx_en = 2;
    localparam int c_ctrl_ie    = 3;
    localparam int c_ctrl_abort = 4;

    // STATUS bit that clears done when written with 1.
    localparam int c_status_done = 1;

    // Byte shifted out when the source side is disabled.
    localparam logic [7:0] c_tx_fill = 8'hFF;

endpackage : spi_dma_pkg
`default_nettype wire

// File: rtl/spi_dma.sv
`default_nettype none
// ============================================================================
//  Module   : spi_dma
//  Purpose  : Byte-wise DMA between data memory and an external SPI master.
//             Each byte: optional memory read (src), one SPI exchange,
//             optional memory write (dst) of the received byte.
//  Ports    : clk, rst_n          - clock, async active-low reset
//             cfg_wen/addr/wdata  - CPU register write port
//             cfg_rdata           - combinational register read
//             mem_req/gnt/addr/wen/wdata/byt/rdata - data-memory master port
//             spi_tx_data/start/ready, spi_rx_data - SPI master handshake
//             irq                 - done & ie
//  Revision : 1.0  initial release
// ============================================================================
module spi_dma
    import spi_dma_pkg::*;
#(
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_wen,
    input  logic [2:0]    cfg_addr,
    input  logic [15:0]   cfg_wdata,
    output logic [15:0]   cfg_rdata,
    output logic          mem_req,
    input  logic          mem_gnt,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wen,
    output logic [15:0]   mem_wdata,
    output logic          mem_byt,
    input  logic [15:0]   mem_rdata,
    output logic [7:0]    spi_tx_data,
    output logic          spi_tx_start,
    input  logic          spi_tx_ready,
    input  logic [7:0]    spi_rx_data,
    output logic          irq
);

    state_t        r_state;
    state_t        w_state_nxt;
    state_t        w_adv_state;

    logic [AW-1:0] r_src, r_dst, r_len;      // programmed registers
    logic [AW-1:0] r_wsrc, r_wdst, r_wlen;   // working counters
    logic          r_tx_en, r_rx_en, r_ie;
    logic          r_done;
    logic [7:0]    r_tx_byte, r_rx_byte;
    logic          r_seen_low;               // spi_tx_ready fell during this byte

    logic          w_busy;
    logic          w_ctrl_wr;
    logic          w_abort;
    logic          w_start;
    logic          w_xfer_done;
    logic          w_advance;
    logic          w_last;
    logic          w_cfg_idle_wr;

    assign w_busy        = (r_state != ST_IDLE);
    assign w_ctrl_wr     = cfg_wen && (cfg_addr == c_reg_ctrl);
    // Abort wins over start when both bits are set in one write.
    assign w_abort       = w_ctrl_wr && cfg_wdata[c_ctrl_abort] && w_busy;
    assign w_start       = w_ctrl_wr && cfg_wdata[c_ctrl_start] &&
                           !cfg_wdata[c_ctrl_abort] && !w_busy;
    assign w_cfg_idle_wr = cfg_wen && !w_busy;
    // A byte is complete only after ready has dropped and come back.
    assign w_xfer_done   = (r_state == ST_XFER_WAIT) && r_seen_low && spi_tx_ready;
    assign w_advance     = !w_abort &&
                           ((w_xfer_done && !r_rx_en) ||
                            ((r_state == ST_WR) && mem_gnt));
    assign w_last        = (r_wlen == AW'(1));
    assign w_adv_state   = w_last ? ST_FIN : (r_tx_en ? ST_RD : ST_XFER);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (w_abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        if (r_len == '0)
                            w_state_nxt = ST_FIN;
                        else if (cfg_wdata[c_ctrl_tx_en])
                            w_state_nxt = ST_RD;
                        else
                            w_state_nxt = ST_XFER;
                    end
                end
                ST_RD:        if (mem_gnt) w_state_nxt = ST_RD_WAIT;
                ST_RD_WAIT:   w_state_nxt = ST_XFER;
                ST_XFER:      if (spi_tx_ready) w_state_nxt = ST_XFER_WAIT;
                ST_XFER_WAIT: begin
                    if (w_xfer_done)
                        w_state_nxt = r_rx_en ? ST_WR : w_adv_state;
                end
                ST_WR:        if (mem_gnt) w_state_nxt = w_adv_state;
                ST_FIN:       w_state_nxt = ST_IDLE;
                default:      w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        mem_req      = 1'b0;
        mem_wen      = 1'b0;
        mem_addr     = r_wsrc;
        spi_tx_start = 1'b0;
        case (r_state)
            ST_RD: begin
                mem_req  = !w_abort;
            end
            ST_WR: begin
                mem_req  = !w_abort;
                mem_wen  = 1'b1;
                mem_addr = r_wdst;
            end
            ST_XFER: begin
                // Gated by ready so a start is never issued to a busy master.
                spi_tx_start = spi_tx_ready && !w_abort;
            end
            default: ;
        endcase
    end

    assign mem_wdata   = {8'd0, r_rx_byte};
    assign mem_byt     = 1'b1;
    assign spi_tx_data = r_tx_byte;
    assign irq         = r_done && r_ie;

    // ------------------------------------------------------------------
    // Register file and datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_src      <= '0;
            r_dst      <= '0;
            r_len      <= '0;
            r_wsrc     <= '0;
            r_wdst     <= '0;
            r_wlen     <= '0;
            r_tx_en    <= 1'b0;
            r_rx_en    <= 1'b0;
            r_ie       <= 1'b0;
            r_done     <= 1'b0;
            r_tx_byte  <= '0;
            r_rx_byte  <= '0;
            r_seen_low <= 1'b0;
        end else begin
            if (w_cfg_idle_wr && (cfg_addr == c_reg_src)) r_src <= AW'(cfg_wdata);
            if (w_cfg_idle_wr && (cfg_addr == c_reg_dst)) r_dst <= AW'(cfg_wdata);
            if (w_cfg_idle_wr && (cfg_addr == c_reg_len)) r_len <= AW'(cfg_wdata);

            // Direction enables are frozen while a transfer runs; ie is not.
            if (w_ctrl_wr) begin
                r_ie <= cfg_wdata[c_ctrl_ie];
                if (!w_busy) begin
                    r_tx_en <= cfg_wdata[c_ctrl_tx_en];
                    r_rx_en <= cfg_wdata[c_ctrl_rx_en];
                end
            end

            if (w_start) begin
                r_wsrc    <= r_src;
                r_wdst    <= r_dst;
                r_wlen    <= r_len;
                r_tx_byte <= c_tx_fill;   // overwritten per byte when tx_en
            end

            if (r_state == ST_RD_WAIT)
                r_tx_byte <= r_wsrc[0] ? mem_rdata[15:8] : mem_rdata[7:0];

            if (r_state == ST_XFER)
                r_seen_low <= 1'b0;
            else if ((r_state == ST_XFER_WAIT) && !spi_tx_ready)
                r_seen_low <= 1'b1;

            if (w_xfer_done && !w_abort)
                r_rx_byte <= spi_rx_data;

            if (w_advance) begin
                if (r_tx_en) r_wsrc <= r_wsrc + AW'(1);
                if (r_rx_en) r_wdst <= r_wdst + AW'(1);
                r_wlen <= r_wlen - AW'(1);
            end

            // Completion outranks a simultaneous software clear.
            if ((r_state == ST_FIN) && !w_abort)
                r_done <= 1'b1;
            else if (w_start)
                r_done <= 1'b0;
            else if (cfg_wen && (cfg_addr == c_reg_status) && cfg_wdata[c_status_done])
                r_done <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Register read-back
    // ------------------------------------------------------------------
    always_comb begin
        cfg_rdata = 16'd0;
        case (cfg_addr)
            c_reg_src:    cfg_rdata = 16'(r_src);
            c_reg_dst:    cfg_rdata = 16'(r_dst);
            c_reg_len:    cfg_rdata = 16'(r_len);
            c_reg_ctrl:   cfg_rdata = {11'd0, 1'b0, r_ie, r_rx_en, r_tx_en, 1'b0};
            c_reg_status: cfg_rdata = {14'd0, r_done, w_busy};
            default:      cfg_rdata = 16'd0;
        endcase
    end

endmodule : spi_dma
`default_nettype wire
